hi_lo_unit: RTL and testbench
=============================

# hi_lo_unit

Iterative multiply/divide unit for the MIPS execute stage, owning the architectural HI and LO registers. It accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO from the ID/EX stage and holds the pipeline via `busy` while a long operation runs. Its `hi` and `lo` outputs feed the 4-input writeback result-select mux, which picks them for MFHI and MFLO.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: operand and HI/LO width. Only 32 is verified.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `op_valid`  in  1  an operation is presented this cycle.
- `op`  in  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO. Codes 110 and 111 are ignored.
- `operand_a`  in  32  rs value (dividend / multiplicand / MTHI/MTLO source).
- `operand_b`  in  32  rt value (divisor / multiplier).
- `busy`  out  1  a long operation is in flight; upstream must stall.
- `done`  out  1  single-cycle pulse after HI/LO are written by a long operation.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- **States:** IDLE, MUL, DIV, SIGN.
- **Acceptance:** an operation is accepted only in IDLE with `op_valid=1` and a legal `op`.
  - When accepted, operands are converted to magnitudes (signed ops only), and the result sign flags are latched.
  - `op_valid` while `busy=1` is ignored. Upstream stalls, so no op is lost.
- **MTHI/MTLO:** `hi` (or `lo`) is loaded with `operand_a` at the accepting edge. The state stays IDLE and `busy` is never raised.
- **MUL:** 32 shift-add iterations over a 64-bit accumulator, one bit per cycle.
- **DIV:** 32 restoring shift-subtract iterations, one quotient bit per cycle.
- **Iteration counter:** a 5-bit counter runs 0..31 and wraps to 0 on exit from MUL/DIV.
- **SIGN (one cycle):**
  - Signed product is negated if the operand signs differ.
  - Signed quotient sign = sign(a) XOR sign(b).
  - Signed remainder takes the sign of the dividend.
  - `hi`/`lo` are written at the end of SIGN, and the state returns to IDLE.
- **Results:**
  - MULT/MULTU: `hi` = product[63:32], `lo` = product[31:0].
  - DIV/DIVU: `lo` = quotient, `hi` = remainder.
- **Divide by zero** (both DIV and DIVU): `lo=32'hFFFFFFFF`, `hi=operand_a`. Latency is the normal divide latency.
- **DIV overflow** (0x80000000 / 0xFFFFFFFF): `lo=32'h80000000`, `hi=0`. No exception is raised.
- **During a long op:** `hi`/`lo` hold their previous values until the final write.

## Timing
- **Reset:** `reset` high at a rising edge forces, at that edge:
  - state = IDLE, counter = 0;
  - `hi=0`, `lo=0`, `busy=0`, `done=0`.
  - This also applies mid-operation: the in-flight op is aborted with no partial HI/LO write.
- **Long-op sequence:** edge E0 accepts the op.
  - `busy=1` from after E0 through the cycle ending at E33 (33 cycles: 32 iterations + SIGN).
  - `hi`/`lo` are valid after E33, and `busy=0` after E33.
  - `done=1` for exactly the cycle between E33 and E34.
- **Back-to-back ops:** a new op may be accepted at E33+1, i.e. the first edge with `busy=0`.
- **MTHI/MTLO:** zero stall. The value is visible on `hi`/`lo` the cycle after the accepting edge, and `done` stays 0.
- **Outputs:** `busy`, `done`, `hi` and `lo` are all registered. There is no combinational path from inputs to outputs.

## Configuration
- **`HI_LO_FAST_MULT_EN` defined:**
  - MULT/MULTU use a single-cycle 64-bit multiplier and skip MUL/SIGN.
  - `busy=1` for one cycle after E0, `hi`/`lo` are written at E1, and `done` pulses between E1 and E2.
- **Undefined:** MULT/MULTU use the iterative 33-cycle path described above.
- Divide behaviour is identical in both builds.

## Test plan
- Reset, then MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → `hi=0xFFFFFFFE`, `lo=0x00000001`.
  - Iterative build: `busy` high for exactly 33 cycles, with `done` one cycle after it falls.
  - Fast build: `busy` high for 1 cycle.
- MULT a=0xFFFFFFFD (-3), b=5 → `hi=0xFFFFFFFF`, `lo=0xFFFFFFF1`.
- DIV a=0xFFFFFFF9 (-7), b=2 → `lo=0xFFFFFFFD` (-3), `hi=0xFFFFFFFF` (-1).
  - DIVU a=7, b=2 → `lo=3`, `hi=1`.
- DIVU a=0x12345678, b=0 → `lo=0xFFFFFFFF`, `hi=0x12345678` after 33 busy cycles.
- DIV 0x80000000 / 0xFFFFFFFF → `lo=0x80000000`, `hi=0`.
- MTLO 0xA5A5A5A5 in IDLE → `lo=0xA5A5A5A5` next cycle with `busy=0`.
- MTHI presented during DIV → ignored; `hi` shows only the divide result.
- Assert `reset` on cycle 10 of a DIV → next cycle shows `busy=0`, `hi=lo=0`, `done=0`, and no `done` pulse ever follows.

Source files
------------

// File: rtl/hi_lo_unit.sv
// hi_lo_unit
//   Iterative multiply/divide unit owning the architectural HI and LO
//   registers. Accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO and holds the
//   pipeline through busy while a long operation iterates.
//
//   Optional feature macro: HI_LO_FAST_MULT_EN
//     defined   : MULT/MULTU complete through a single-cycle 64-bit multiplier
//     undefined : MULT/MULTU use the 32-step shift-add path
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   op_valid   in   an operation is presented this cycle
//   op         in   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   operand_a  in   rs value (dividend / multiplicand / MTHI-MTLO source)
//   operand_b  in   rt value (divisor / multiplier)
//   busy       out  long operation in flight, upstream must stall
//   done       out  one-cycle pulse after a long op writes HI/LO
//   hi, lo     out  HI and LO registers
//
// state | meaning
// IDLE  | waiting for an operation, MTHI/MTLO complete here
// MUL   | shift-add iterations, one multiplier bit per cycle
// DIV   | restoring shift-subtract iterations, one quotient bit per cycle
// SIGN  | sign fix-up of the magnitude result, HI/LO written on exit
module hi_lo_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);
    localparam int W = DATA_WIDTH;
    localparam logic [4:0] CNT_LAST = 5'(W - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, SIGN} state_t;

    state_t state, state_nxt;
    logic   busy_nxt, done_nxt;

    logic [4:0]     cnt;
    logic [2*W-1:0] acc;       // {remainder, quotient} or running product
    logic [W-1:0]   opb;       // multiplicand or divisor magnitude
    logic           is_div;
    logic           neg_hi;    // negate remainder, or whole product for multiply
    logic           neg_lo;    // negate quotient
    logic           div_zero;

    logic accept, accept_long, op_signed, is_fast_mult;
    logic [W-1:0] a_mag, b_mag;

    assign accept      = op_valid && (state == IDLE) && (op <= 3'b101);
    assign accept_long = accept && !op[2];
    assign op_signed   = !op[0];
    assign a_mag = (op_signed && operand_a[W-1]) ? -operand_a : operand_a;
    assign b_mag = (op_signed && operand_b[W-1]) ? -operand_b : operand_b;

`ifdef HI_LO_FAST_MULT_EN
    logic [2*W-1:0] fast_prod;
    always_comb begin
        if (op_signed)
            fast_prod = {{W{operand_a[W-1]}}, operand_a} * {{W{operand_b[W-1]}}, operand_b};
        else
            fast_prod = {{W{1'b0}}, operand_a} * {{W{1'b0}}, operand_b};
    end
    assign is_fast_mult = (op[2:1] == 2'b00);
`else
    assign is_fast_mult = 1'b0;
`endif

    // iteration datapath
    logic [W:0] mul_sum, div_shift, div_trial;
    logic       div_ge;
    assign mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opb} : {(W+1){1'b0}});
    assign div_shift = {acc[2*W-1:W], acc[W-1]};
    assign div_ge    = (div_shift >= {1'b0, opb});
    assign div_trial = div_shift - {1'b0, opb};

    // sign fix-up results
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix, rem_fix;
    assign prod_fix = neg_hi ? -acc : acc;
    assign quo_fix  = neg_lo ? -acc[W-1:0] : acc[W-1:0];
    assign rem_fix  = neg_hi ? -acc[2*W-1:W] : acc[2*W-1:W];

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept_long) begin
                if (is_fast_mult)  state_nxt = SIGN;
                else if (op[1])    state_nxt = DIV;
                else               state_nxt = MUL;
            end
            MUL, DIV: if (cnt == CNT_LAST) state_nxt = SIGN;
            SIGN: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // output logic, registered below so nothing reaches the ports combinationally
    always_comb begin
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state == SIGN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_nxt;
            done <= done_nxt;
        end
    end

    // datapath and HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            acc      <= '0;
            opb      <= '0;
            is_div   <= 1'b0;
            neg_hi   <= 1'b0;
            neg_lo   <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    if (op == 3'b100) hi <= operand_a;
                    if (op == 3'b101) lo <= operand_a;
                    if (accept_long) begin
                        cnt      <= '0;
                        is_div   <= op[1];
                        div_zero <= op[1] && (operand_b == '0);
                        neg_lo   <= op_signed && (operand_a[W-1] ^ operand_b[W-1]);
                        if (op[1]) begin
                            neg_hi <= op_signed && operand_a[W-1];
                            acc    <= {{W{1'b0}}, a_mag};
                            opb    <= b_mag;
                        end else begin
                            neg_hi <= op_signed && (operand_a[W-1] ^ operand_b[W-1]);
                            acc    <= {{W{1'b0}}, b_mag};
                            opb    <= a_mag;
`ifdef HI_LO_FAST_MULT_EN
                            // product is already signed-correct
                            neg_hi <= 1'b0;
                            acc    <= fast_prod;
`endif
                        end
                    end
                end
                MUL: begin
                    acc <= {mul_sum, acc[W-1:1]};
                    cnt <= cnt + 5'd1;
                end
                DIV: begin
                    if (div_ge) acc <= {div_trial[W-1:0], acc[W-2:0], 1'b1};
                    else        acc <= {div_shift[W-1:0], acc[W-2:0], 1'b0};
                    cnt <= cnt + 5'd1;
                end
                SIGN: begin
                    if (!is_div) begin
                        hi <= prod_fix[2*W-1:W];
                        lo <= prod_fix[W-1:0];
                    end else if (div_zero) begin
                        // the magnitude remainder is |a|, so sign fix-up restores a
                        hi <= rem_fix;
                        lo <= {W{1'b1}};
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hi_lo_unit.sv
module tb_hi_lo_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] operand_a, operand_b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    hi_lo_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, act, exp);
    endtask

    function automatic int exp_lat(input logic [2:0] o);
`ifdef HI_LO_FAST_MULT_EN
        if (o <= 3'd1) return 1;
`endif
        return 33;
    endfunction

    // architectural result of one operation, plain 64-bit arithmetic
    task automatic ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, p, q, r;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd1: begin up = {32'd0, a} * {32'd0, b}; m_hi = up[63:32]; m_lo = up[31:0]; end
            3'd2: if (b == 0) begin m_lo = 32'hFFFFFFFF; m_hi = a; end
                  else begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
            3'd3: if (b == 0) begin m_lo = 32'hFFFFFFFF; m_hi = a; end
                  else begin m_lo = a / b; m_hi = a % b; end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    // called at a negedge with the unit idle; returns at a negedge with the unit idle
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit mt_during);
        logic [31:0] old_hi, old_lo;
        int lat;
        old_hi = m_hi;
        old_lo = m_lo;
        op_valid = 1'b1; op = o; operand_a = a; operand_b = b;
        @(negedge clk);
        op_valid = 1'b0;
        ref_op(o, a, b);
        if (o <= 3'd3) begin
            lat = 0;
            while (busy === 1'b1 && lat < 100) begin
                if (lat == 0) begin
                    chk("hold_hi", hi, old_hi);
                    chk("hold_lo", lo, old_lo);
                end
                if (mt_during) begin
                    op_valid = 1'b1; op = 3'd4; operand_a = $urandom;
                end
                @(negedge clk);
                op_valid = 1'b0;
                lat++;
            end
            chk($sformatf("lat_op%0d", o), lat, exp_lat(o));
            chk("done_pulse", done, 1'b1);
            chk($sformatf("hi_op%0d", o), hi, m_hi);
            chk($sformatf("lo_op%0d", o), lo, m_lo);
            @(negedge clk);
            chk("done_end", done, 1'b0);
        end else begin
            chk("short_busy", busy, 1'b0);
            chk("short_done", done, 1'b0);
            chk($sformatf("hi_op%0d", o), hi, m_hi);
            chk($sformatf("lo_op%0d", o), lo, m_lo);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int dones;
        reset = 1'b1; op_valid = 1'b0; op = '0; operand_a = '0; operand_b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);

        do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        chk("multu_hi_const", hi, 32'hFFFFFFFE);
        chk("multu_lo_const", lo, 32'h00000001);
        do_op(3'd0, 32'hFFFFFFFD, 32'd5, 0);
        chk("mult_lo_const", lo, 32'hFFFFFFF1);
        do_op(3'd2, 32'hFFFFFFF9, 32'd2, 0);
        chk("div_lo_const", lo, 32'hFFFFFFFD);
        chk("div_hi_const", hi, 32'hFFFFFFFF);
        do_op(3'd3, 32'd7, 32'd2, 0);
        do_op(3'd3, 32'h12345678, 32'h0, 0);
        chk("divz_hi_const", hi, 32'h12345678);
        do_op(3'd2, 32'h80000000, 32'h0, 0);
        do_op(3'd2, 32'hFFFFFFF9, 32'h0, 0);
        do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0);
        chk("ovf_lo_const", lo, 32'h80000000);
        do_op(3'd5, 32'hA5A5A5A5, 32'h0, 0);
        do_op(3'd6, 32'h11111111, 32'h0, 0);
        do_op(3'd2, 32'd100, 32'd7, 1);
        chk("mthi_ignored", hi, 32'd2);
        do_op(3'd4, 32'hDEADBEEF, 32'h0, 0);
        // back-to-back: next op presented at the first idle negedge
        do_op(3'd0, 32'h7FFFFFFF, 32'h80000000, 0);

        for (int i = 0; i < 60; i++)
            do_op(3'($urandom_range(0, 7)), pick(), pick(), bit'($urandom_range(0, 1)));

        // reset in the middle of a divide
        op_valid = 1'b1; op = 3'd2; operand_a = 32'd12345; operand_b = 32'd3;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        chk("abort_no_done", dones, 0);
        do_op(3'd3, 32'd7, 32'd2, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
